// File: rtl/reg_file_if.sv
// reg_file_if: read/write port bundle for the reg_file register file.
// The master side drives addresses, the write strobe and stall; the slave
// side (reg_file) returns the registered read data.
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic              stall;
  logic [ADDR_W-1:0] read_addr_0;
  logic [ADDR_W-1:0] read_addr_1;
  logic [DATA_W-1:0] readdata_0;
  logic [DATA_W-1:0] readdata_1;
  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] writedata;

  modport master (
    output stall,
    output read_addr_0,
    output read_addr_1,
    input  readdata_0,
    input  readdata_1,
    output write_en,
    output write_addr,
    output writedata
  );

  modport slave (
    input  stall,
    input  read_addr_0,
    input  read_addr_1,
    output readdata_0,
    output readdata_1,
    input  write_en,
    input  write_addr,
    input  writedata
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W general-purpose register file, two registered
// read ports and one write port. Entry 0 is hardwired to zero. stall freezes
// both read outputs while writes continue.
// Optional build macro: REG_FILE_BYPASS_EN -- when defined, a same-cycle
// write to the address being read is forwarded to that read port
// (write-first); when undefined the port returns the old contents.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic       clk,
  input logic       rst_n,
  reg_file_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd0;
  logic [DATA_W-1:0] r_rd1;

  logic              w_wr_valid;
  logic [DATA_W-1:0] w_rd0;
  logic [DATA_W-1:0] w_rd1;

  // A write is effective only when strobed and not aimed at entry 0.
  assign w_wr_valid = bus.write_en && (bus.write_addr != '0);

  // Select next read data for each port, optionally forwarding the write.
  always_comb begin
    w_rd0 = r_mem[bus.read_addr_0];
    w_rd1 = r_mem[bus.read_addr_1];
`ifdef REG_FILE_BYPASS_EN
    if (w_wr_valid && (bus.write_addr == bus.read_addr_0)) w_rd0 = bus.writedata;
    if (w_wr_valid && (bus.write_addr == bus.read_addr_1)) w_rd1 = bus.writedata;
`endif
  end

  // Storage array: cleared on reset, entry 0 is never written so it stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_valid) begin
      r_mem[bus.write_addr] <= bus.writedata;
    end
  end

  // Registered read ports, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd0 <= '0;
      r_rd1 <= '0;
    end else if (!bus.stall) begin
      r_rd0 <= w_rd0;
      r_rd1 <= w_rd1;
    end
  end

  assign bus.readdata_0 = r_rd0;
  assign bus.readdata_1 = r_rd1;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed + randomized bench for reg_file against an array
// reference model of the register file.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) u_if ();

  reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  // Downstream operand mux: inputdata_0 = readdata_1, inputdata_1 = immediate.
  logic          selecter;
  logic [DW-1:0] immdata;
  logic [DW-1:0] outputdata;
  assign outputdata = selecter ? immdata : u_if.readdata_1;

  // Reference model state.
  logic [DW-1:0] m_mem [32];
  logic [DW-1:0] m_rd0;
  logic [DW-1:0] m_rd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_rd0 = '0;
    m_rd1 = '0;
  endtask

  // One clock: drive on negedge, update model at posedge, check after #1.
  task automatic step(input logic st, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                      input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic wr_ok;
    @(negedge clk);
    u_if.stall       = st;
    u_if.read_addr_0 = ra0;
    u_if.read_addr_1 = ra1;
    u_if.write_en    = we;
    u_if.write_addr  = wa;
    u_if.writedata   = wd;
    @(posedge clk);
    wr_ok = we && (wa != 0);
    if (!st) begin
      m_rd0 = m_mem[ra0];
      m_rd1 = m_mem[ra1];
`ifdef REG_FILE_BYPASS_EN
      if (wr_ok && wa == ra0) m_rd0 = wd;
      if (wr_ok && wa == ra1) m_rd1 = wd;
`endif
    end
    if (wr_ok) m_mem[wa] = wd;
    #1;
    check("model_rd0", u_if.readdata_0, m_rd0);
    check("model_rd1", u_if.readdata_1, m_rd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    selecter = 1'b0;
    immdata  = '0;
    u_if.stall = 1'b0;
    u_if.read_addr_0 = '0;
    u_if.read_addr_1 = '0;
    u_if.write_en = 1'b0;
    u_if.write_addr = '0;
    u_if.writedata = '0;
    model_reset();

    // Power-on reset: outputs clear without any clock edge.
    rst_n = 1'b0;
    #1;
    check("por_rd0", u_if.readdata_0, 32'h0);
    check("por_rd1", u_if.readdata_1, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 32'h12345678);
    step(1'b0, 5'd5, 5'd31, 1'b0, 5'd0, 32'h0);
    check("basic_r5", u_if.readdata_0, 32'hDEADBEEF);
    check("basic_r31", u_if.readdata_1, 32'h12345678);

    // Register 0 ignores writes.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    check("r0_rd0", u_if.readdata_0, 32'h0);
    check("r0_rd1", u_if.readdata_1, 32'h0);

    // Stall hold while r5 is rewritten.
    step(1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd31, 5'd0, 1'b1, 5'd5, 32'hAAAA5555);
      check("stall_hold", u_if.readdata_0, 32'hDEADBEEF);
    end
    step(1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0);
    check("stall_release", u_if.readdata_0, 32'hAAAA5555);

    // Same-cycle read/write on r7.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h11111111);
    step(1'b0, 5'd7, 5'd0, 1'b1, 5'd7, 32'h22222222);
`ifdef REG_FILE_BYPASS_EN
    check("rw_same_r7", u_if.readdata_0, 32'h22222222);
`else
    check("rw_same_r7", u_if.readdata_0, 32'h11111111);
`endif
    step(1'b0, 5'd7, 5'd0, 1'b0, 5'd0, 32'h0);
    check("rw_next_r7", u_if.readdata_0, 32'h22222222);

    // Operand mux integration.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h0000CAFE);
    step(1'b0, 5'd0, 5'd9, 1'b0, 5'd0, 32'h0);
    check("mux_sel0", outputdata, 32'h0000CAFE);
    selecter = 1'b1;
    immdata  = 32'h0BADF00D;
    #1;
    check("mux_sel1", outputdata, 32'h0BADF00D);
    selecter = 1'b0;

    // Randomized traffic, small address pool to force collisions.
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] a0, a1, wa;
      a0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      wa = ($urandom_range(0, 1) == 0) ? a0 : AW'($urandom_range(0, 7));
      step(($urandom_range(0, 3) == 0), a0, a1, $urandom_range(0, 1) == 1, wa, $urandom);
    end

    // Mid-cycle reset after writes; a write during reset is lost.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_rd0", u_if.readdata_0, 32'h0);
    check("midrst_rd1", u_if.readdata_1, 32'h0);
    @(negedge clk);
    u_if.stall = 1'b0;
    u_if.write_en = 1'b1;
    u_if.write_addr = 5'd3;
    u_if.writedata = 32'h5A5A5A5A;
    @(posedge clk);
    @(negedge clk);
    u_if.write_en = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i < 32; i += 2) begin
      step(1'b0, AW'(i), AW'((i + 1) % 32), 1'b0, 5'd0, 32'h0);
      check("postrst_rd0", u_if.readdata_0, 32'h0);
      check("postrst_rd1", u_if.readdata_1, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
